// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: SRL/SLL/SRA/ROR/ROL plus pass-through, one
// register per shift-amount bit (MSB applied first), valid/ready handshake
// with a global stall, and a sideband tag carried alongside each operation.
module barrel_shift_pipe #(
  parameter int WIDTH  = 64,
  parameter int SAMT_W = $clog2(WIDTH),
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   D_in,
  input  logic [SAMT_W-1:0]  samt,
  input  logic [2:0]         op,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   D_out,
  output logic [TAG_W-1:0]   tag_out
);

  localparam logic [2:0] OP_SRL = 3'd0;
  localparam logic [2:0] OP_SLL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;

  // Stage registers: stage k holds the operand after the shifts of
  // stages 0..k have been applied.
  logic [SAMT_W-1:0] valid_reg;
  logic [WIDTH-1:0]  data_reg [SAMT_W];
  logic [SAMT_W-1:0] samt_reg [SAMT_W];
  logic [2:0]        op_reg   [SAMT_W];
  logic [TAG_W-1:0]  tag_reg  [SAMT_W];

  // Values presented to each stage (from the ports for stage 0, from the
  // previous register otherwise) and the shifted data each stage captures.
  logic [SAMT_W-1:0] stage_valid;
  logic [WIDTH-1:0]  stage_data [SAMT_W];
  logic [SAMT_W-1:0] stage_samt [SAMT_W];
  logic [2:0]        stage_op   [SAMT_W];
  logic [TAG_W-1:0]  stage_tag  [SAMT_W];
  logic [WIDTH-1:0]  data_next  [SAMT_W];

  logic stall;

  // One fixed-distance shift step. SRA fills from the current MSB, which
  // after any earlier SRA step is still the original sign bit. The shift
  // distance is at most WIDTH/2, so the rotate complement never reaches WIDTH.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       o,
    input int               sh
  );
    logic [WIDTH-1:0] r;
    case (o)
      OP_SRL:  r = d >> sh;
      OP_SLL:  r = d << sh;
      OP_SRA:  r = $signed(d) >>> sh;
      OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
      OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
      default: r = d;
    endcase
    return r;
  endfunction

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = valid_reg[SAMT_W-1];
  assign D_out     = data_reg[SAMT_W-1];
  assign tag_out   = tag_reg[SAMT_W-1];

  generate
    for (genvar gi = 0; gi < SAMT_W; gi++) begin : g_stage
      localparam int SH = 1 << (SAMT_W - 1 - gi);

      if (gi == 0) begin : g_head
        assign stage_valid[gi] = in_valid;
        assign stage_data[gi]  = D_in;
        assign stage_samt[gi]  = samt;
        assign stage_op[gi]    = op;
        assign stage_tag[gi]   = tag_in;
      end else begin : g_body
        assign stage_valid[gi] = valid_reg[gi-1];
        assign stage_data[gi]  = data_reg[gi-1];
        assign stage_samt[gi]  = samt_reg[gi-1];
        assign stage_op[gi]    = op_reg[gi-1];
        assign stage_tag[gi]   = tag_reg[gi-1];
      end

      assign data_next[gi] = stage_samt[gi][SAMT_W-1-gi]
                           ? shift_step(stage_data[gi], stage_op[gi], SH)
                           : stage_data[gi];
    end
  endgenerate

  // Advance every stage together unless the output is blocked; a bubble
  // enters stage 0 whenever no input is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      for (int k = 0; k < SAMT_W; k++) begin
        data_reg[k] <= '0;
        samt_reg[k] <= '0;
        op_reg[k]   <= '0;
        tag_reg[k]  <= '0;
      end
    end else if (!stall) begin
      valid_reg <= stage_valid;
      for (int k = 0; k < SAMT_W; k++) begin
        data_reg[k] <= data_next[k];
        samt_reg[k] <= stage_samt[k];
        op_reg[k]   <= stage_op[k];
        tag_reg[k]  <= stage_tag[k];
      end
    end
  end

  // The last stage's amount and mode have already been consumed.
  logic unused_tail;
  assign unused_tail = ^{samt_reg[SAMT_W-1], op_reg[SAMT_W-1]};

endmodule

// File: doc/barrel_shift_pipe.md
Name: barrel_shift_pipe

Overview:
- Parametrised, pipelined successor to the team's 64-bit, 5-bit-amount combinational logical right barrel shifter.
- Adds:
  - Generic data width with the full shift-amount range 0..WIDTH-1.
  - Five shift modes: logical left/right, arithmetic right, rotate left/right.
  - One register per shift stage.
  - Valid/ready handshake with full-pipeline stall on backpressure.
  - A sideband tag that travels with each operation.
- Sits between the operand-issue logic and the writeback/result path of the datapath.

Parameters:
- WIDTH, 64, data width; power of two, >= 2.
- SAMT_W, $clog2(WIDTH), shift-amount width (derived; do not override).
- TAG_W, 4, sideband tag width (>= 1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- D_in  in  WIDTH  operand.
- samt  in  SAMT_W  shift amount.
- op  in  3  mode select. 000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101-111 pass-through.
- tag_in  in  TAG_W  sideband tag, returned unmodified.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- D_out  out  WIDTH  shifted result.
- tag_out  out  TAG_W  tag for the result on D_out.

Behaviour:
- Reset: synchronous, active-high. On a clk edge with rst=1:
  - All stage valid bits cleared.
  - All data, samt, op and tag stage registers cleared to 0.
  - out_valid=0, D_out=0, tag_out=0.
  - The first cycle after reset deasserts has in_ready=1.
  - Reset mid-operation discards every in-flight operation; no partial result is emitted.
- Pipeline structure:
  - SAMT_W registered stages. Stage k (k=0..SAMT_W-1) applies shift bit samt[SAMT_W-1-k], i.e. a shift of 2^(SAMT_W-1-k); MSB is applied first.
  - Each stage register holds: valid, data, remaining samt bits, op, tag.
- Latency: an input accepted at edge N (in_valid && in_ready) appears on D_out/tag_out with out_valid=1 after edge N+SAMT_W-1. At WIDTH=64 that is 6 registered stages, so the result is visible in the 6th cycle after acceptance.
- Throughput: one operation per cycle when not stalled.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall, purely combinational from the output stage.
  - While stalled, every stage register holds its value; D_out, tag_out and out_valid are stable.
  - Bubbles are not compressed during a stall; a global stall is the required behaviour.
- Handshake:
  - Input is accepted only when in_valid && in_ready. When in_valid=0 and the pipeline is not stalled, a bubble (valid=0) enters stage 0.
  - Output transfers when out_valid && out_ready; the next stage's contents advance in the same edge.
  - out_ready is ignored while out_valid=0.
- Mode rules, per stage, shift by s:
  - SRL: zero-fill from the MSB.
  - SLL: zero-fill from the LSB.
  - SRA: fill with the original D_in[WIDTH-1], carried or preserved through the stages.
  - ROR: bits leaving at the LSB re-enter at the MSB.
  - ROL: bits leaving at the MSB re-enter at the LSB.
  - Pass-through (op 101-111): D_out = D_in, regardless of samt.
- Shift boundaries:
  - samt=0: D_out = D_in in all modes.
  - samt=WIDTH-1: maximum shift; no shift of WIDTH or more is representable.
- tag_in, and op for the purposes of the result, are captured at acceptance and never altered.

Test Plan (WIDTH=64, TAG_W=4):
- Mode checks: issue back-to-back with out_ready=1 and in_valid held high for 5 cycles:
  - SRL D_in=0x8000_0000_0000_0001, samt=63, tag=1 -> D_out=0x0000_0000_0000_0001.
  - SLL D_in=0xFF, samt=60, tag=2 -> 0xF000_0000_0000_0000.
  - SRA D_in=0x8000_0000_0000_0000, samt=4, tag=3 -> 0xF800_0000_0000_0000.
  - ROR D_in=0x1, samt=1, tag=4 -> 0x8000_0000_0000_0000.
  - ROL D_in=0x8000_0000_0000_0001, samt=4, tag=5 -> 0x0000_0000_0000_0018.
  - Required response: the five results appear in order on consecutive cycles, the first 6 cycles after acceptance, with matching tags.
- Boundaries: samt=0 in every op -> D_out=D_in. op=110 with samt=17, D_in=0x1234 -> 0x1234. SRA of 0x7FFF_FFFF_FFFF_FFFF with samt=63 -> 0x0.
- Backpressure: fill the pipeline with 6 operations, then drop out_ready for 4 cycles.
  - in_ready=0 and D_out/tag_out are held constant throughout.
  - After out_ready rises, all 6 results drain in order with no loss or duplication.
- Bubbles: alternate in_valid 1/0 -> out_valid toggles with the same spacing, shifted by the pipeline latency.
- Reset mid-operation: assert rst for 1 cycle while 3 operations are in flight.
  - Next cycle: out_valid=0, D_out=0, tag_out=0, in_ready=1.
  - No in-flight result ever appears.
  - A new operation issued afterwards returns correctly after 6 cycles.
- Randomised: random op, samt, D_in and out_ready checked against a reference-model scoreboard for 10k operations at WIDTH=64, and again at WIDTH=8.
